r200ex_ctrl: RTL and testbench

Execute-stage controller for the r200 core. It accepts decoded operations from decode through a valid/ready handshake, holds them in the EX slot and drives the combinational execute datapath (`r200ex`, instantiated inside). It registers each result into a writeback slot with a second valid/ready handshake. It resolves branches and jumps, issues a one-cycle redirect to fetch and squashes the decode operation that arrives behind a taken control transfer.

---
 rtl/r200_pkg.sv | 38 +++
 rtl/r200ex.sv | 53 +++++
 rtl/r200ex_perf.sv | 23 ++
 rtl/r200ex_ctrl.sv | 124 ++++++++++++
 tb/tb_r200ex_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/r200_pkg.sv
// Shared types and constants for the r200 execute stage: FSM states,
// branch condition encodings and the EX-slot record.
package r200_pkg;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_SQUASH = 2'd2
    } ex_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic               alu_cont;
        logic [2:0]         func3;
        logic [XLEN-1:0]    jump_imm;
        logic [XLEN-1:0]    jump_addimm;
        logic               isbranch;
        logic               isjump;
        logic [RADDR_W-1:0] rd;
        logic               wben;
    } ex_slot_t;

    // An op carrying both class bits is treated as a jump.
    function automatic logic is_taken(input logic isbranch, input logic isjump,
                                      input logic willbr);
        return isjump | (isbranch & willbr);
    endfunction
endpackage

// File: rtl/r200ex.sv
// Combinational execute datapath: ALU, branch condition and branch target.
module r200ex
    import r200_pkg::*;
(
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            alu_cont,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] jump_imm,
    input  logic [XLEN-1:0] jump_addimm,
    output logic [XLEN-1:0] alu_res,
    output logic            willbr,
    output logic [XLEN-1:0] pc_jumptarg
);
    logic                   eq, lt_s, lt_u;
    logic [4:0]             shamt;
    logic signed [XLEN-1:0] sra;

    assign eq          = (op1 == op2);
    assign lt_s        = ($signed(op1) < $signed(op2));
    assign lt_u        = (op1 < op2);
    assign shamt       = op2[4:0];
    // Kept as its own signed net so the shift stays arithmetic.
    assign sra         = $signed(op1) >>> shamt;
    assign pc_jumptarg = jump_imm + jump_addimm;

    always_comb begin
        alu_res = '0;
        case (func3)
            3'b000:  alu_res = alu_cont ? (op1 - op2) : (op1 + op2);
            3'b001:  alu_res = op1 << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100:  alu_res = op1 ^ op2;
            3'b101:  alu_res = alu_cont ? sra : (op1 >> shamt);
            3'b110:  alu_res = op1 | op2;
            default: alu_res = op1 & op2;
        endcase
    end

    always_comb begin
        willbr = 1'b0;
        case (func3)
            F3_BEQ:  willbr = eq;
            F3_BNE:  willbr = ~eq;
            F3_BLT:  willbr = lt_s;
            F3_BGE:  willbr = ~lt_s;
            F3_BLTU: willbr = lt_u;
            F3_BGEU: willbr = ~lt_u;
            default: willbr = 1'b0;
        endcase
    end
endmodule

// File: rtl/r200ex_perf.sv
// Wrapping 32-bit performance counters for the execute stage.
module r200ex_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    input  logic        taken,
    input  logic        stall,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_taken,
    output logic [31:0] perf_wbstall
);
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired <= '0;
            perf_taken   <= '0;
            perf_wbstall <= '0;
        end else begin
            if (retire) perf_retired <= perf_retired + 32'd1;
            if (taken)  perf_taken   <= perf_taken + 32'd1;
            if (stall)  perf_wbstall <= perf_wbstall + 32'd1;
        end
    end
endmodule

// File: rtl/r200ex_ctrl.sv
// Execute-stage controller: EX slot, registered WB slot, redirect and squash bubble.
// Define R200_EX_PERF_EN to build live performance counters (tied to 0 otherwise).
module r200ex_ctrl #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [XLEN-1:0]    id_op1,
    input  logic [XLEN-1:0]    id_op2,
    input  logic               id_alu_cont,
    input  logic [2:0]         id_func3,
    input  logic [XLEN-1:0]    id_jump_imm,
    input  logic [XLEN-1:0]    id_jump_addimm,
    input  logic               id_isbranch,
    input  logic               id_isjump,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_wben,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [XLEN-1:0]    wb_res,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_wben,
    output logic               redir_valid,
    output logic [XLEN-1:0]    redir_pc,
    output logic [31:0]        perf_retired,
    output logic [31:0]        perf_taken,
    output logic [31:0]        perf_wbstall
);
    import r200_pkg::*;

    ex_state_t       state, state_nxt;
    ex_slot_t        slot;
    logic            move, accept, taken, willbr;
    logic [XLEN-1:0] alu_res, pc_jumptarg;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // An op accepted while a taken transfer leaves is dropped by going to SQUASH.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_EXEC;
            ST_EXEC:   if (move)   state_nxt = taken ? ST_SQUASH :
                                               (accept ? ST_EXEC : ST_IDLE);
            ST_SQUASH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        move     = (state == ST_EXEC) && (!wb_valid || wb_ready);
        id_ready = (state == ST_IDLE) || move;
        accept   = id_valid && id_ready;
        taken    = move && is_taken(slot.isbranch, slot.isjump, willbr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (accept) begin
            slot <= '{op1: id_op1, op2: id_op2, alu_cont: id_alu_cont,
                      func3: id_func3, jump_imm: id_jump_imm,
                      jump_addimm: id_jump_addimm, isbranch: id_isbranch,
                      isjump: id_isjump, rd: id_rd, wben: id_wben};
        end
    end

    r200ex u_ex (
        .op1         (slot.op1),
        .op2         (slot.op2),
        .alu_cont    (slot.alu_cont),
        .func3       (slot.func3),
        .jump_imm    (slot.jump_imm),
        .jump_addimm (slot.jump_addimm),
        .alu_res     (alu_res),
        .willbr      (willbr),
        .pc_jumptarg (pc_jumptarg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_res      <= '0;
            wb_rd       <= '0;
            wb_wben     <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else begin
            if (move) begin
                wb_valid <= 1'b1;
                wb_res   <= alu_res;
                wb_rd    <= slot.rd;
                wb_wben  <= slot.wben & ~slot.isbranch;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
            redir_valid <= taken;
            if (taken) redir_pc <= pc_jumptarg;
        end
    end

`ifdef R200_EX_PERF_EN
    r200ex_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .retire       (wb_valid & wb_ready),
        .taken        (redir_valid),
        .stall        (wb_valid & ~wb_ready),
        .perf_retired (perf_retired),
        .perf_taken   (perf_taken),
        .perf_wbstall (perf_wbstall)
    );
`else
    assign perf_retired = '0;
    assign perf_taken   = '0;
    assign perf_wbstall = '0;
`endif
endmodule

// File: tb/tb_r200ex_ctrl.sv
// Bench for r200ex_ctrl: vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_r200ex_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_ready;
    logic [31:0] id_op1 = '0, id_op2 = '0, id_jump_imm = '0, id_jump_addimm = '0;
    logic        id_alu_cont = 1'b0, id_isbranch = 1'b0, id_isjump = 1'b0, id_wben = 1'b0;
    logic [2:0]  id_func3 = '0;
    logic [4:0]  id_rd = '0;
    logic        wb_valid, wb_ready = 1'b1, wb_wben, redir_valid;
    logic [31:0] wb_res, redir_pc, perf_retired, perf_taken, perf_wbstall;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    r200ex_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_op1(id_op1), .id_op2(id_op2), .id_alu_cont(id_alu_cont),
        .id_func3(id_func3), .id_jump_imm(id_jump_imm), .id_jump_addimm(id_jump_addimm),
        .id_isbranch(id_isbranch), .id_isjump(id_isjump), .id_rd(id_rd),
        .id_wben(id_wben), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_res(wb_res), .wb_rd(wb_rd), .wb_wben(wb_wben),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .perf_retired(perf_retired), .perf_taken(perf_taken), .perf_wbstall(perf_wbstall)
    );

`ifdef R200_EX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  f3;
        logic        cont;
        logic [31:0] a, b, ji, ja;
        logic        isb, isj, wben;
        logic [31:0] res;
        logic        exp_wben, exp_redir;
        logic [31:0] pc;
    } vec_t;
    vec_t vt [20];

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wben;
    } wb_exp_t;
    wb_exp_t exp_q[$];
    wb_exp_t e;

    logic        inflight, prev_redir, prev_stall, prev_wben;
    logic [31:0] inflight_pc, prev_res;
    logic [4:0]  prev_rd;
    int          n_acc;
    int unsigned r_cls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic cont,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ji, input logic [31:0] ja,
                         input logic isb, input logic isj,
                         input logic [4:0] rd, input logic wben);
        id_valid = 1'b1; id_func3 = f3; id_alu_cont = cont; id_op1 = a; id_op2 = b;
        id_jump_imm = ji; id_jump_addimm = ja; id_isbranch = isb; id_isjump = isj;
        id_rd = rd; id_wben = wben;
    endtask

    task automatic add_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        drive(3'b000, 1'b0, a, b, 32'h0, 32'h0, 1'b0, 1'b0, rd, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; id_valid = 1'b0; wb_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_res"}, wb_res, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_wb_wben"}, wb_wben, 0);
        chk({tag, "_redir_valid"}, redir_valid, 0);
        chk({tag, "_redir_pc"}, redir_pc, 0);
        chk({tag, "_perf_retired"}, perf_retired, 0);
        chk({tag, "_perf_taken"}, perf_taken, 0);
        chk({tag, "_perf_wbstall"}, perf_wbstall, 0);
        chk({tag, "_id_ready"}, id_ready, 1);
    endtask

    // Reference ALU built from the operation meanings, not the datapath's structure.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic cont,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh = b % 32;
        fill = (a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (f3)
            3'd0:    return cont ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return cont ? ((a >> sh) | fill) : (a >> sh);
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, input logic isb, input logic isj);
        if (isj) return 1'b1;
        if (!isb) return 1'b0;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return int'(a) < int'(b);
            3'd5:    return int'(a) >= int'(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //        f3    c  a             b             ji        ja        isb isj wb  res           ew er pc
        vt[0]  = '{3'd0,0, 32'd3,        32'd4,        32'h0,    32'h0,    0, 0, 1, 32'd7,        1, 0, 32'h0};
        vt[1]  = '{3'd0,0, 32'd10,       32'hFFFFFFFE, 32'h0,    32'h0,    0, 0, 1, 32'd8,        1, 0, 32'h0};
        vt[2]  = '{3'd0,1, 32'd5,        32'd7,        32'h0,    32'h0,    0, 0, 1, 32'hFFFFFFFE, 1, 0, 32'h0};
        vt[3]  = '{3'd1,0, 32'd1,        32'd4,        32'h0,    32'h0,    0, 0, 1, 32'h10,       1, 0, 32'h0};
        vt[4]  = '{3'd2,0, 32'hFFFFFFFF, 32'd1,        32'h0,    32'h0,    0, 0, 1, 32'd1,        1, 0, 32'h0};
        vt[5]  = '{3'd3,0, 32'hFFFFFFFF, 32'd1,        32'h0,    32'h0,    0, 0, 1, 32'd0,        1, 0, 32'h0};
        vt[6]  = '{3'd4,0, 32'hF0F0,     32'hFF00,     32'h0,    32'h0,    0, 0, 1, 32'h0FF0,     1, 0, 32'h0};
        vt[7]  = '{3'd5,0, 32'h80000000, 32'd4,        32'h0,    32'h0,    0, 0, 1, 32'h08000000, 1, 0, 32'h0};
        vt[8]  = '{3'd5,1, 32'h80000000, 32'd4,        32'h0,    32'h0,    0, 0, 1, 32'hF8000000, 1, 0, 32'h0};
        vt[9]  = '{3'd6,0, 32'hF0,       32'h0F,       32'h0,    32'h0,    0, 0, 1, 32'hFF,       1, 0, 32'h0};
        vt[10] = '{3'd7,0, 32'hF0,       32'h3C,       32'h0,    32'h0,    0, 0, 1, 32'h30,       1, 0, 32'h0};
        vt[11] = '{3'd0,0, 32'd5,        32'd5,        32'h100,  32'h20,   1, 0, 1, 32'hA,        0, 1, 32'h120};
        vt[12] = '{3'd1,0, 32'd5,        32'd5,        32'h100,  32'h20,   1, 0, 1, 32'hA0,       0, 0, 32'h0};
        vt[13] = '{3'd4,0, 32'hFFFFFFFE, 32'd1,        32'h200,  32'h4,    1, 0, 0, 32'hFFFFFFFF, 0, 1, 32'h204};
        vt[14] = '{3'd5,0, 32'hFFFFFFFE, 32'd1,        32'h200,  32'h4,    1, 0, 0, 32'h7FFFFFFF, 0, 0, 32'h0};
        vt[15] = '{3'd6,0, 32'd1,        32'hFFFFFFFF, 32'h10,   32'h10,   1, 0, 0, 32'hFFFFFFFF, 0, 1, 32'h20};
        vt[16] = '{3'd7,0, 32'd1,        32'hFFFFFFFF, 32'h10,   32'h10,   1, 0, 0, 32'd1,        0, 0, 32'h0};
        vt[17] = '{3'd0,0, 32'h400,      32'd4,        32'h1000, 32'h2C,   0, 1, 1, 32'h404,      1, 1, 32'h102C};
        vt[18] = '{3'd0,0, 32'd1,        32'd1,        32'h0,    32'h0,    0, 0, 0, 32'd2,        0, 0, 32'h0};
        vt[19] = '{3'd7,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h30,   32'h30,   1, 0, 1, 32'hFFFFFFFF, 0, 1, 32'h60};

        // Power-on reset
        tick();
        chk_reset("por");
        rst = 1'b0;
        @(negedge clk);
        chk("por_id_ready_after", id_ready, 1);
        tick();

        // Single ops into an idle pipeline
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].f3, vt[i].cont, vt[i].a, vt[i].b, vt[i].ji, vt[i].ja,
                  vt[i].isb, vt[i].isj, 5'(i + 1), vt[i].wben);
            @(negedge clk);
            chk($sformatf("v%0d_id_ready", i), id_ready, 1);
            tick();
            id_valid = 1'b0;
            tick();
            chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            chk($sformatf("v%0d_wb_res", i), wb_res, vt[i].res);
            chk($sformatf("v%0d_wb_rd", i), wb_rd, i + 1);
            chk($sformatf("v%0d_wb_wben", i), wb_wben, vt[i].exp_wben);
            chk($sformatf("v%0d_redir_valid", i), redir_valid, vt[i].exp_redir);
            if (vt[i].exp_redir) chk($sformatf("v%0d_redir_pc", i), redir_pc, vt[i].pc);
            tick();
            chk($sformatf("v%0d_redir_pulse", i), redir_valid, 0);
            tick();
        end

        // Reset while EXEC holds an op and the WB slot is full
        do_reset();
        wb_ready = 1'b0;
        add_op(32'd1, 32'd1, 5'd3);
        tick();
        add_op(32'd2, 32'd2, 5'd4);
        tick();
        id_valid = 1'b0;
        chk("rst_mid_pre_wb_valid", wb_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rst_mid");
        wb_ready = 1'b1;
        tick();
        chk("rst_mid_no_ghost", wb_valid, 0);

        // Back-to-back ADDs
        do_reset();
        add_op(32'd3, 32'd4, 5'd1);
        tick();
        add_op(32'd10, 32'hFFFFFFFE, 5'd2);
        @(negedge clk);
        chk("b2b_id_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        chk("b2b_res0", wb_res, 7);
        chk("b2b_valid0", wb_valid, 1);
        tick();
        chk("b2b_res1", wb_res, 8);
        chk("b2b_valid1", wb_valid, 1);
        tick();
        chk("b2b_drained", wb_valid, 0);

        // Taken BEQ: redirect, op behind it squashed, next offer refused
        do_reset();
        drive(3'b000, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b0, 5'd3, 1'b1);
        tick();
        add_op(32'd1, 32'd1, 5'd9);
        tick();
        chk("beq_redir_valid", redir_valid, 1);
        chk("beq_redir_pc", redir_pc, 32'h120);
        chk("beq_wb_wben", wb_wben, 0);
        @(negedge clk);
        chk("beq_squash_id_ready", id_ready, 0);
        tick();
        id_valid = 1'b0;
        chk("beq_redir_pulse", redir_valid, 0);
        chk("beq_squashed_op", wb_valid, 0);
        @(negedge clk);
        chk("beq_idle_id_ready", id_ready, 1);
        tick();
        chk("beq_no_ghost", wb_valid, 0);

        // Not-taken BNE: no bubble
        do_reset();
        drive(3'b001, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b0, 5'd3, 1'b1);
        tick();
        add_op(32'd2, 32'd2, 5'd5);
        @(negedge clk);
        chk("bne_id_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        chk("bne_redir_valid", redir_valid, 0);
        chk("bne_wb_wben", wb_wben, 0);
        tick();
        chk("bne_next_valid", wb_valid, 1);
        chk("bne_next_res", wb_res, 4);

        // WB back-pressure for three cycles with a full pipeline
        do_reset();
        wb_ready = 1'b0;
        add_op(32'd1, 32'd2, 5'd1);
        tick();
        add_op(32'd5, 32'd5, 5'd2);
        tick();
        add_op(32'd7, 32'd7, 5'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_id_ready", i), id_ready, 0);
            chk($sformatf("stall%0d_wb_res", i), wb_res, 3);
            chk($sformatf("stall%0d_wb_valid", i), wb_valid, 1);
            tick();
        end
        chk("stall_perf_wbstall", perf_wbstall, PERF ? 3 : 0);
        chk("stall_perf_retired0", perf_retired, 0);
        wb_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_id_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        chk("stall_perf_retired1", perf_retired, PERF ? 1 : 0);
        chk("stall_res_b", wb_res, 10);
        tick();
        chk("stall_res_c", wb_res, 14);
        tick();
        chk("stall_drained", wb_valid, 0);
        chk("stall_perf_retired3", perf_retired, PERF ? 3 : 0);

        // JAL: link value, write enable, redirect, taken counter
        do_reset();
        drive(3'b000, 1'b0, 32'h400, 32'd4, 32'h800, 32'h10, 1'b0, 1'b1, 5'd1, 1'b1);
        tick();
        id_valid = 1'b0;
        tick();
        chk("jal_wb_res", wb_res, 32'h404);
        chk("jal_wb_wben", wb_wben, 1);
        chk("jal_redir_valid", redir_valid, 1);
        chk("jal_redir_pc", redir_pc, 32'h810);
        tick();
        chk("jal_perf_taken", perf_taken, PERF ? 1 : 0);
        chk("jal_redir_pulse", redir_valid, 0);

        // Randomized traffic against the transaction-level model
        do_reset();
        inflight = 1'b0; inflight_pc = '0;
        prev_redir = 1'b0; prev_stall = 1'b0;
        prev_res = '0; prev_rd = '0; prev_wben = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (redir_valid) begin
                chk("rnd_redir_expected", inflight, 1);
                chk("rnd_redir_pc", redir_pc, inflight_pc);
                inflight = 1'b0;
            end
            if (prev_redir) chk("rnd_redir_pulse", redir_valid, 0);
            if (prev_stall) begin
                chk("rnd_hold_valid", wb_valid, 1);
                chk("rnd_hold_res", wb_res, prev_res);
                chk("rnd_hold_rd", wb_rd, prev_rd);
                chk("rnd_hold_wben", wb_wben, prev_wben);
            end
            if (c < 2900) begin
                r_cls = $urandom_range(0, 7);
                drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(0, 6) : $urandom,
                      $urandom, $urandom, $urandom,
                      (r_cls == 1 || r_cls == 2), (r_cls == 0),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) id_op2 = id_op1;
                else if ($urandom_range(0, 1) != 0) id_op2 = $urandom_range(0, 6);
                id_valid = ($urandom_range(0, 3) != 0);
                wb_ready = ($urandom_range(0, 2) != 0);
            end else begin
                id_valid = 1'b0;
                wb_ready = 1'b1;
            end
            @(negedge clk);
            if (redir_valid) chk("rnd_squash_id_ready", id_ready, 0);
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rnd_wb_unexpected: got res 0x%08h expected no writeback", wb_res);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_wb_res", wb_res, e.res);
                    chk("rnd_wb_rd", wb_rd, e.rd);
                    chk("rnd_wb_wben", wb_wben, e.wben);
                end
            end
            if (id_valid && id_ready) begin
                n_acc++;
                // Ops accepted behind a taken transfer, before its redirect, are flushed.
                if (!inflight) begin
                    exp_q.push_back('{res: ref_alu(id_func3, id_alu_cont, id_op1, id_op2),
                                      rd: id_rd, wben: id_wben & ~id_isbranch});
                    if (ref_taken(id_func3, id_op1, id_op2, id_isbranch, id_isjump)) begin
                        inflight = 1'b1;
                        inflight_pc = id_jump_imm + id_jump_addimm;
                    end
                end
            end
            prev_redir = redir_valid;
            prev_stall = wb_valid && !wb_ready;
            prev_res   = wb_res;
            prev_rd    = wb_rd;
            prev_wben  = wb_wben;
            tick();
        end
        chk("rnd_queue_empty", exp_q.size(), 0);
        chk("rnd_no_inflight", inflight, 0);
        chk("rnd_activity", (n_acc > 500) ? 32'd1 : 32'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
